mul_div_seq: RTL and testbench

Sequencing controller for the MiniSRC multiply/divide unit. Accepts a MUL or DIV request from the control unit, drives the combinational Booth carry-save multiplier array and resolves its sum/carry vectors into a 64-bit product with a two-cycle split 32-bit add. It also runs a 32-iteration restoring signed divider. Results land in the HI/LO registers, which feed the register-file write path.

---
 rtl/mul_div_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_mul_div_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_seq.sv
// Sequencing controller for the MiniSRC multiply/divide unit (HI/LO results).
// Latency: MUL 2 cycles, DIV 34 cycles, div-by-zero 1 cycle, reserved op 0 cycles.
// Backpressure: none; start is only sampled in IDLE, requests during busy are dropped.
// Optional divider datapath is compiled in when MULDIV_DIV_EN is defined.
module mul_div_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_sum,
    input  logic [63:0] mul_carry,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_LO   = 3'd1,
        S_MUL_HI   = 3'd2
`ifdef MULDIV_DIV_EN
        ,
        S_DIV_PREP = 3'd3,
        S_DIV_ITER = 3'd4,
        S_DIV_FIX  = 3'd5
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic [31:0] r_lo_sum;
    logic        r_cout;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // The array's carry vector is unshifted; weight it by two before resolving.
    logic [63:0] w_carry_sh;
    logic [32:0] w_lo_add;
    logic [31:0] w_hi_add;

    assign w_carry_sh = {mul_carry[62:0], 1'b0};
    assign w_lo_add   = {1'b0, mul_sum[31:0]} + {1'b0, w_carry_sh[31:0]};
    assign w_hi_add   = mul_sum[63:32] + w_carry_sh[63:32] + {31'd0, r_cout};

`ifdef MULDIV_DIV_EN
    // r_quo holds the raw dividend, then |dividend|, and shifts into the quotient.
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [31:0] r_rem;
    logic [4:0]  r_count;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_qbit;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // Partial remainder is 33 bits wide only transiently, after the shift-in.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[32];
    assign w_quo_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
    assign w_rem_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;
`endif

    // Next-state and completion-pulse decode.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (op == 2'b00) begin
                        w_state_nxt = S_MUL_LO;
                    end
`ifdef MULDIV_DIV_EN
                    else if (op == 2'b01) begin
                        w_state_nxt = S_DIV_PREP;
                    end
`endif
                    else begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end
                end
            end
            S_MUL_LO: w_state_nxt = S_MUL_HI;
            S_MUL_HI: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
`ifdef MULDIV_DIV_EN
            S_DIV_PREP: begin
                if (r_dvs == 32'd0) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_DIV_ITER;
                end
            end
            S_DIV_ITER: begin
                if (r_count == 5'd0) begin
                    w_state_nxt = S_DIV_FIX;
                end
            end
            S_DIV_FIX: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus registered busy/done/err so the outputs are glitch-free.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Multiplier operands, split product add and the HI/LO result registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_mul_a  <= 32'd0;
            r_mul_b  <= 32'd0;
            r_lo_sum <= 32'd0;
            r_cout   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && op == 2'b00) begin
                        r_mul_a <= a;
                        r_mul_b <= b;
                    end
                end
                S_MUL_LO: begin
                    r_lo_sum <= w_lo_add[31:0];
                    r_cout   <= w_lo_add[32];
                end
                S_MUL_HI: begin
                    r_hi <= w_hi_add;
                    r_lo <= r_lo_sum;
                end
`ifdef MULDIV_DIV_EN
                S_DIV_PREP: begin
                    if (r_dvs == 32'd0) begin
                        r_hi <= r_quo;
                        r_lo <= 32'hFFFF_FFFF;
                    end
                end
                S_DIV_FIX: begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef MULDIV_DIV_EN
    // Restoring divider on magnitudes; signs are reapplied in DIV_FIX.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_quo   <= 32'd0;
            r_dvs   <= 32'd0;
            r_rem   <= 32'd0;
            r_count <= 5'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && op == 2'b01) begin
                        r_quo <= a;
                        r_dvs <= b;
                    end
                end
                S_DIV_PREP: begin
                    if (r_dvs != 32'd0) begin
                        r_neg_q <= r_quo[31] ^ r_dvs[31];
                        r_neg_r <= r_quo[31];
                        r_quo   <= r_quo[31] ? (32'd0 - r_quo) : r_quo;
                        r_dvs   <= r_dvs[31] ? (32'd0 - r_dvs) : r_dvs;
                        r_rem   <= 32'd0;
                        r_count <= 5'd31;
                    end
                end
                S_DIV_ITER: begin
                    r_rem   <= w_qbit ? w_diff[31:0] : w_shift[31:0];
                    r_quo   <= {r_quo[30:0], w_qbit};
                    r_count <= r_count - 5'd1;
                end
                default: ;
            endcase
        end
    end
`endif

    assign mul_a = r_mul_a;
    assign mul_b = r_mul_b;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq: directed cases plus random MUL/DIV/reserved ops
// checked against an arithmetic reference; the multiplier array is modelled as a
// random carry-save split of the true product.
module tb_mul_div_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_sum;
    logic [63:0] mul_carry;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [63:0] carry_rand;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_asserts = 0;
    int          n_fail    = 0;

    mul_div_seq dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_sum   (mul_sum),
        .mul_carry (mul_carry),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Array model: any sum/carry pair with sum + 2*carry == signed product.
    always_comb begin
        logic signed [63:0] pa;
        logic signed [63:0] pb;
        pa = {{32{mul_a[31]}}, mul_a};
        pb = {{32{mul_b[31]}}, mul_b};
        mul_carry = carry_rand;
        mul_sum   = (pa * pb) - {carry_rand[62:0], 1'b0};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, optionally pulse a stray start mid-operation, check the result.
    task automatic do_op(input logic [1:0] t_op, input logic [31:0] t_a,
                         input logic [31:0] t_b, input int poke);
        int          lat_exp;
        int          lat;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_err;
        longint      la;
        longint      lb;
        longint      q;
        longint      r;
        longint      p;
        la = longint'($signed(t_a));
        lb = longint'($signed(t_b));
        e_hi = m_hi; e_lo = m_lo; e_err = 1'b1; lat_exp = 0;
        if (t_op == 2'b00) begin
            p = la * lb;
            e_hi = p[63:32]; e_lo = p[31:0]; e_err = 1'b0; lat_exp = 2;
        end
`ifdef MULDIV_DIV_EN
        else if (t_op == 2'b01) begin
            if (t_b == 32'd0) begin
                e_hi = t_a; e_lo = 32'hFFFF_FFFF; e_err = 1'b1; lat_exp = 1;
            end else begin
                q = la / lb; r = la % lb;
                e_hi = r[31:0]; e_lo = q[31:0]; e_err = 1'b0; lat_exp = 34;
            end
        end
`endif
        carry_rand = {$urandom, $urandom};
        op = t_op; a = t_a; b = t_b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        chk("busy_after_accept", busy, (lat_exp > 0));
        lat = 0;
        while (!done && lat < 60) begin
            if (poke != 0 && lat == poke) begin
                start = 1'b1; op = 2'b00;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        chk("latency", lat, lat_exp);
        chk("err", err, e_err);
        chk("hi", hi, e_hi);
        chk("lo", lo, e_lo);
        chk("busy_at_done", busy, 1'b0);
        if (t_op == 2'b00) begin
            chk("mul_a_held", mul_a, t_a);
            chk("mul_b_held", mul_b, t_b);
        end
        m_hi = hi; m_lo = lo;
        if (lat == lat_exp) begin
            m_hi = e_hi; m_lo = e_lo;
        end
    endtask

    task automatic chk_quiet();
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
        chk("err_one_cycle", err, 1'b0);
        chk("idle_not_busy", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        carry_rand = 64'd0; m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_mul_b", mul_b, 32'd0);
        clr = 1'b0;
        @(posedge clk); #1;

        // Directed multiplies, including a back-to-back start in the done cycle.
        do_op(2'b00, 32'd7, 32'hFFFF_FFFD, 0);
        chk_quiet();
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        do_op(2'b00, 32'hFFFF_FFFF, 32'd1, 0);
        chk_quiet();

        // Reserved opcodes complete immediately with err and keep HI/LO.
        do_op(2'b10, 32'd11, 32'd22, 0);
        do_op(2'b11, 32'd33, 32'd44, 0);
        chk_quiet();

        // Divides (reserved-like when the divider is compiled out).
        do_op(2'b01, 32'hFFFF_FF9C, 32'd7, 0);
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(2'b01, 32'd5, 32'd0, 0);
        do_op(2'b01, 32'hFFFF_FF9C, 32'd7, 5);
        chk_quiet();

        // Stray start during a multiply is ignored.
        do_op(2'b00, 32'd3, 32'd5, 1);

        // Random mix of operations.
        for (int i = 0; i < 30; i++) begin
            int          sel;
            logic [31:0] ra;
            logic [31:0] rb;
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            if (sel < 5)      do_op(2'b00, ra, rb, 0);
            else if (sel < 9) do_op(2'b01, ra, rb, 0);
            else              do_op(2'($urandom_range(2, 3)), ra, rb, 0);
        end

        // Asynchronous abort mid-operation zeroes HI/LO.
        do_op(2'b00, 32'd3, 32'd5, 0);
`ifdef MULDIV_DIV_EN
        op = 2'b01; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
`else
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
`endif
        chk("abort_busy_before", busy, 1'b1);
        clr = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_done", done, 1'b0);
        @(posedge clk); #1;
        clr = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk); #1;
        do_op(2'b00, 32'd3, 32'd4, 0);
        chk_quiet();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
